// File: rtl/ln_row_streamer.sv
// Captures a flattened SEQ_LEN x EMB_DIM tensor in one transfer and replays it
// one element per beat, row-major, over a valid/ready stream.
module ln_row_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 8,
    parameter int EMB_DIM    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] x_in,
    input  logic                                  flush,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic [((SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1)-1:0] m_row,
    output logic [((EMB_DIM > 1) ? $clog2(EMB_DIM) : 1)-1:0] m_col,
    output logic                                  m_last_col,
    output logic                                  m_last,
    output logic                                  done
);
    localparam int RW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int CW = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [SEQ_LEN][EMB_DIM];

    logic          capture;
    logic          advance;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush wins over the final handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_STREAM;
            S_STREAM: begin
                if (flush)                  state_nxt = S_IDLE;
                else if (m_ready && m_last) state_nxt = S_DONE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready = 1'b0;
        m_valid  = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE:   in_ready = 1'b1;
            S_STREAM: m_valid  = 1'b1;
            S_DONE:   done     = 1'b1;
            default:  ;
        endcase
    end

    assign capture = in_valid && in_ready;
    // The final beat leaves the indices parked so they never exceed the bounds
    assign advance = m_valid && m_ready && !m_last;

    always_comb begin
        col_nxt = m_last_col ? '0 : m_col + CW'(1);
        row_nxt = m_last_col ? m_row + RW'(1) : m_row;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < SEQ_LEN; r++)
                for (int c = 0; c < EMB_DIM; c++)
                    mem[r][c] <= '0;
            m_data     <= '0;
            m_row      <= '0;
            m_col      <= '0;
            m_last_col <= 1'b0;
            m_last     <= 1'b0;
        end else if (capture) begin
            for (int r = 0; r < SEQ_LEN; r++)
                for (int c = 0; c < EMB_DIM; c++)
                    mem[r][c] <= x_in[(r*EMB_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
            m_data     <= x_in[DATA_WIDTH-1:0];
            m_row      <= '0;
            m_col      <= '0;
            m_last_col <= (EMB_DIM == 1);
            m_last     <= (EMB_DIM == 1) && (SEQ_LEN == 1);
        end else if (advance) begin
            m_data     <= mem[row_nxt][col_nxt];
            m_row      <= row_nxt;
            m_col      <= col_nxt;
            m_last_col <= (col_nxt == CW'(EMB_DIM-1));
            m_last     <= (col_nxt == CW'(EMB_DIM-1)) && (row_nxt == RW'(SEQ_LEN-1));
        end
    end

endmodule

// File: tb/tb_ln_row_streamer.sv
// Directed bench for ln_row_streamer: free-run, backpressure, busy ignore,
// flush, synchronous reset and back-to-back capture.
module tb_ln_row_streamer;
    localparam int DW = 16;
    localparam int SL = 8;
    localparam int ED = 8;
    localparam int N  = SL*ED;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW*N-1:0]   x_in;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [2:0]        m_row;
    logic [2:0]        m_col;
    logic              m_last_col;
    logic              m_last;
    logic              done;

    int checks = 0;
    int errors = 0;

    ln_row_streamer #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .EMB_DIM(ED)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_row(m_row), .m_col(m_col), .m_last_col(m_last_col),
        .m_last(m_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW*N-1:0] pat();
        logic [DW*N-1:0] v;
        for (int r = 0; r < SL; r++)
            for (int c = 0; c < ED; c++)
                v[(r*ED+c)*DW +: DW] = 16'(16'h0100*r + c);
        return v;
    endfunction

    function automatic logic [DW*N-1:0] fill(input logic [DW-1:0] val);
        logic [DW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = val;
        return v;
    endfunction

    // Called from IDLE, one cycle after posedge; returns #1 after the capture edge
    task automatic capture(input logic [DW*N-1:0] t);
        in_valid = 1'b1;
        x_in     = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("cap_in_ready", in_ready, 0);
    endtask

    // Checks every presented beat; stops early (with m_ready=1) when stop_at is reached,
    // otherwise returns #1 after the edge entering the done cycle.
    task automatic run_stream(input bit toggle, input bit fixed, input logic [DW-1:0] fv,
                              input int stop_at);
        int beat = 0;
        int cyc  = 0;
        bit rdy;
        logic [DW-1:0] e;
        while (beat < N && cyc < 2000) begin
            e = fixed ? fv : 16'(16'h0100*(beat/ED) + beat%ED);
            chk("valid", m_valid, 1);
            chk("data", m_data, e);
            chk("row", m_row, beat/ED);
            chk("col", m_col, beat%ED);
            chk("last_col", m_last_col, (beat%ED) == ED-1);
            chk("last", m_last, beat == N-1);
            chk("in_ready_busy", in_ready, 0);
            if (beat == stop_at) begin
                m_ready = 1'b1;
                return;
            end
            rdy = toggle ? (cyc%4 == 0 || cyc%4 == 3) : 1'b1;
            m_ready = rdy;
            @(posedge clk); #1;
            if (rdy) beat++;
            cyc++;
        end
        chk("beats_delivered", beat, N);
        chk("done_pulse", done, 1);
        chk("done_m_valid", m_valid, 0);
        chk("done_in_ready", in_ready, 0);
    endtask

    task automatic finish_idle();
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_done", done, 0);
        chk("idle_m_valid", m_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x_in = '0; flush = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Free-running stream
        m_ready = 1'b1;
        capture(pat());
        run_stream(1'b0, 1'b0, '0, -1);
        finish_idle();

        // Backpressure 1,0,0,1
        capture(pat());
        run_stream(1'b1, 1'b0, '0, -1);
        finish_idle();

        // Busy ignore: offer an all-FFFF tensor throughout the stream
        capture(pat());
        in_valid = 1'b1;
        x_in     = fill(16'hFFFF);
        run_stream(1'b0, 1'b0, '0, -1);
        in_valid = 1'b0;
        finish_idle();
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_second_stream", m_valid, 0);
        end

        // Flush while beat (2,5) handshakes
        capture(pat());
        run_stream(1'b0, 1'b0, '0, 2*ED+5);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_m_valid", m_valid, 0);
        chk("flush_done", done, 0);
        chk("flush_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("flush_no_done", done, 0);
        capture(pat());
        run_stream(1'b0, 1'b0, '0, -1);
        finish_idle();

        // Synchronous reset at beat (4,3)
        capture(pat());
        run_stream(1'b0, 1'b0, '0, 4*ED+3);
        rst_n = 1'b0;
        #2;
        chk("rst_sync_hold", m_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_m_valid", m_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_data", m_data, 0);
        chk("rst_mid_row", m_row, 0);
        @(posedge clk); #1;
        chk("rst_no_done", done, 0);

        // Back-to-back: in_valid stays high with the next tensor waiting
        in_valid = 1'b1;
        x_in     = pat();
        @(posedge clk); #1;
        x_in = fill(16'h5A5A);
        run_stream(1'b0, 1'b0, '0, -1);
        @(posedge clk); #1;
        chk("b2b_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_captured", in_ready, 0);
        run_stream(1'b0, 1'b1, 16'h5A5A, -1);
        finish_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
